spi_eeprom_responder: RTL
=========================

// Module: spi_eeprom_responder
// PURPOSE
//  Synthesizable SPI mode-0 slave that answers the M95xxx-style serial EEPROM command set.
//  It is the responder counterpart to the chip's SPI master; it lets the master be exercised
//  on-board or in-sim without the vendor model.
//  Oversamples spi_clk/mosi/ss in the clk domain and serves data from an external synchronous RAM port.
// PARAMETERS
//  ADDR_W      16   byte-address width; address wraps modulo 2**ADDR_W
//  PAGE_BYTES  32   write page size (power of 2); write address wraps inside the page
//  SYNC_STAGES 2    synchronizer depth for spi_clk, mosi, ss
// PORTS
//  clk        in   1       system clock (>= 8x spi_clk)
//  reset      in   1       asynchronous, active-high reset
//  spi_clk    in   1       SPI SCK from master, idle low (mode 0)
//  ss         in   1       slave select, active low
//  mosi       in   1       master-out data, sampled on SCK rise
//  miso       out  1       slave-out data, updated on SCK fall
//  miso_oe    out  1       1 = drive miso (ss low and in a data-out phase)
//  mem_addr   out  ADDR_W  RAM byte address
//  mem_rdata  in   8       RAM read data, valid 1 clk after mem_addr
//  mem_wdata  out  8       RAM write data
//  mem_we     out  1       1-clk write strobe
// BEHAVIOUR
//  Reset values: miso=0, miso_oe=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, WEL=0.
//  Inputs pass SYNC_STAGES flops, then edge detect; all logic runs on clk.
//  Events: sck_rise, sck_fall, ss_fall, ss_rise. Added latency is SYNC_STAGES+1 clk per event.
//  Bits are MSB first. Bit counter 0..7 advances on sck_rise; the byte completes on the 8th rise.
//  Opcodes: WREN 0x06, WRDI 0x04, RDSR 0x05, READ 0x03, WRITE 0x02. Any other opcode -> IGNORE.
//  FSM (ss_fall -> CMD):
//   CMD: at byte end, decode opcode:
//     WREN sets WEL; WRDI clears WEL; both -> IGNORE.
//     RDSR -> STATUS; READ/WRITE -> ADDR_HI.
//   ADDR_HI -> ADDR_LO: each captures 8 address bits (ADDR_W>8: upper unused bits dropped).
//   ADDR_LO byte end:
//     READ: issue mem_addr, capture mem_rdata next clk into the tx shift reg -> DATA_RD.
//     WRITE with WEL=1 -> DATA_WR.
//     WRITE with WEL=0 -> IGNORE.
//   DATA_RD: miso_oe=1; miso shows tx[7] from load, shifts on each sck_fall.
//     On the 8th sck_rise of a byte, addr+1 (mod 2**ADDR_W) and prefetch.
//     The reload happens before the next sck_fall, so the stream is continuous.
//   DATA_WR: each complete byte -> mem_wdata=byte, mem_we=1 for 1 clk, then addr advances.
//     Advance is {addr[ADDR_W-1:log2 PAGE], (addr+1)[log2 PAGE-1:0]} (page wrap).
//   STATUS: shifts out {6'b0, WEL, WIP=0} repeatedly while ss low.
//   IGNORE: miso_oe=0, consume bits until ss_rise.
//  ss_rise in any state:
//    -> IDLE, miso_oe=0, bit counter cleared.
//    A partial byte is discarded (no write).
//    If the command was WRITE, clear WEL (even if 0 bytes were written).
//  ss_fall while not IDLE (glitch) restarts at CMD.
//  sck edges while ss high are ignored.
//  Reset mid-transfer: immediate return to the reset values; WEL cleared.
//  Simultaneous ss_rise and sck_rise in the same clk: ss_rise wins, the bit is dropped.
// STRUCTURE
//  Shared package spi_eeprom_pkg: opcode localparams, state encoding, status bit positions.
//  Sub-module spi_sync_edge: per-signal synchronizer + rise/fall pulses (instantiated 3x).
//  FSM, shift regs, address counter and WEL live in the top module.
// TESTING
//  1 RAM preloaded 0x1234=A5, 0x1235=3C; READ 03 12 34 + 16 SCKs -> miso bytes A5,3C.
//    miso_oe high only during the data phase.
//  2 RAM[0xFFFF]=11, RAM[0]=22; READ at 0xFFFF for 2 bytes -> 11,22 (address wrap).
//  3 WREN; RDSR -> 0x02. WRITE 02 00 1E DE AD BE -> RAM[1E]=DE, [1F]=AD, [00]=BE (page wrap).
//    Then RDSR -> 0x00 (WEL cleared).
//  4 WRITE without WREN -> no mem_we pulse. Opcode 0xFF -> miso_oe stays 0 until ss rises.
//  5 WREN, WRITE 02 00 10 then 5 bits and ss rises -> no write, WEL=0.
//  6 Assert reset mid-READ -> miso=0, miso_oe=0 immediately; the next READ works normally.

Source files
------------

// File: rtl/spi_eeprom_pkg.sv
// spi_eeprom_pkg: opcodes, FSM encoding and status register layout for the SPI EEPROM responder
package spi_eeprom_pkg;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam int WEL_BIT = 1;
  localparam int WIP_BIT = 0;
  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, DATA_RD, DATA_WR, STATUS, IGNORE} state_t;
  function automatic logic [7:0] status_byte(input logic wel);
    status_byte = (8'(wel) << WEL_BIT) | (8'(1'b0) << WIP_BIT);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with single-clk rise/fall pulses on the synced level
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sr <= STAGES'({sr, d});
      prev <= sr[STAGES-1];
    end
  assign q = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI mode-0 slave emulating an M95xxx-style EEPROM over a synchronous RAM port
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int PAGE_BYTES  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we
);
  localparam logic [ADDR_W-1:0] PMASK = ADDR_W'(PAGE_BYTES - 1);
  logic sck_q, sck_rise, sck_fall, ss_q, ss_rise, ss_fall, mosi_q, mosi_rise, mosi_fall;
  logic unused_sync;
  state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] rx, tx, addr_hi, rx_byte;
  logic [1:0] pf;
  logic wel, is_write, active;
  logic [ADDR_W-1:0] page_next;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (.clk(clk), .reset(reset), .d(spi_clk), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (.clk(clk), .reset(reset), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
  assign unused_sync = ^{sck_q, mosi_rise, mosi_fall};
  assign rx_byte = {rx[6:0], mosi_q};
  assign active = ~ss_q && state != IDLE;
  assign page_next = (mem_addr & ~PMASK) | ((mem_addr + ADDR_W'(1)) & PMASK);
  assign miso = tx[7];
  // pf delays the read-data capture two clks: one for mem_addr to settle, one for RAM latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx <= '0;
      tx <= '0;
      addr_hi <= '0;
      pf <= '0;
      wel <= 1'b0;
      is_write <= 1'b0;
      miso_oe <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      pf <= {pf[0], 1'b0};
      if (mem_we) mem_addr <= page_next;
      if (pf[1] && state == DATA_RD) begin
        tx <= mem_rdata;
        miso_oe <= 1'b1;
      end
      if (ss_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
        miso_oe <= 1'b0;
        is_write <= 1'b0;
        if (is_write) wel <= 1'b0;
      end else if (ss_fall) begin
        state <= CMD;
        bit_cnt <= '0;
        miso_oe <= 1'b0;
        is_write <= 1'b0;
      end else if (active) begin
        // the first fall of each byte keeps the freshly loaded MSB on miso
        if (sck_fall && bit_cnt != 3'd0 && (state == DATA_RD || state == STATUS)) tx <= {tx[6:0], 1'b0};
        if (sck_rise) begin
          rx <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            case (state)
              CMD:
                case (rx_byte)
                  OP_WREN: begin wel <= 1'b1; state <= IGNORE; end
                  OP_WRDI: begin wel <= 1'b0; state <= IGNORE; end
                  OP_RDSR: begin tx <= status_byte(wel); miso_oe <= 1'b1; state <= STATUS; end
                  OP_READ: state <= ADDR_HI;
                  OP_WRITE: begin is_write <= 1'b1; state <= ADDR_HI; end
                  default: state <= IGNORE;
                endcase
              ADDR_HI: begin addr_hi <= rx_byte; state <= ADDR_LO; end
              ADDR_LO: begin
                mem_addr <= ADDR_W'({addr_hi, rx_byte});
                pf[0] <= ~is_write;
                state <= !is_write ? DATA_RD : wel ? DATA_WR : IGNORE;
              end
              DATA_RD: begin mem_addr <= mem_addr + ADDR_W'(1); pf[0] <= 1'b1; end
              DATA_WR: begin mem_wdata <= rx_byte; mem_we <= 1'b1; end
              STATUS: tx <= status_byte(wel);
              default: ;
            endcase
        end
      end
    end
endmodule
